booth_prod_accum: RTL and testbench
===================================

// Module: booth_prod_accum
// PURPOSE
//   Sequential accumulate stage directly downstream of the radix-4 Booth/Wallace multiplier.
//   - Takes one signed 2*WIDTH-bit product per valid/ready beat.
//   - Sums the products into an ACC_W-bit accumulator.
//   - When the beat flagged last arrives, presents the frame total (dot-product result) on a
//     valid/ready output.
//   - Turns the combinational multiplier into a streaming MAC datapath.
// PARAMETERS
//   WIDTH  32  multiplier operand width; product input is 2*WIDTH bits, signed two's complement
//   ACC_W  72  accumulator width; must be >= 2*WIDTH (guard bits above the product)
//   CNT_W  16  term-counter width
// PORTS
//   clk        in   1          single clock; all state updates on its rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   acc_clr    in   1          synchronous abort/clear of the current frame
//   in_valid   in   1          product beat valid
//   in_ready   out  1          stage can accept a beat
//   in_p       in   2*WIDTH    signed product from the multiplier
//   in_last    in   1          beat is the final term of the frame
//   out_valid  out  1          frame result valid
//   out_ready  in   1          consumer accepts result
//   out_acc    out  ACC_W      signed frame sum
//   out_cnt    out  CNT_W      number of terms in the frame
//   out_ovf    out  1          sticky signed overflow seen during the frame
// BEHAVIOUR
//   - Reset (rst_n=0, async):
//     - state=IDLE; acc=0; cnt=0; ovf=0.
//     - out_valid=0, out_acc=0, out_cnt=0, out_ovf=0; in_ready=1 after deassert.
//     - Reset mid-frame or mid-HOLD drops all partial state; no result is emitted.
//   - Input transfer: in_valid && in_ready.
//     - in_p is sign-extended to ACC_W.
//   - FSM states: IDLE, ACCUM, HOLD.
//     - in_ready = (state != HOLD).
//   - IDLE, on transfer:
//     - acc <= sext(in_p); cnt <= 1; ovf <= 0.
//     - Next state: in_last ? HOLD : ACCUM.
//   - ACCUM, on transfer:
//     - acc <= acc + sext(in_p); cnt <= cnt+1, saturating at 2^CNT_W-1.
//     - ovf |= signed overflow (operand signs equal, result sign differs).
//     - in_last -> HOLD.
//   - HOLD:
//     - out_valid=1; out_acc/out_cnt/out_ovf stable until handshake.
//     - On out_valid && out_ready -> IDLE, acc/cnt/ovf cleared next cycle.
//     - No input beats accepted while in HOLD (no bypass).
//   - Latency: result is visible the cycle after the in_last transfer.
//     - Single-beat frame (in_last on the first beat) is legal: out_acc = sext(in_p), out_cnt=1.
//   - acc_clr (sampled each cycle) has priority over any same-cycle transfer:
//     - Any state -> IDLE with acc/cnt/ovf=0; the beat offered that cycle is not consumed.
//     - in_ready is forced 0 in that cycle.
//     - In HOLD the pending result is discarded and out_valid drops the next cycle.
//   - out_acc, out_cnt and out_ovf are registered.
//     - Outside HOLD they show the running value; only meaningful while out_valid=1.
// CONFIGURATION
//   ACC_SATURATE_EN
//     - Defined:
//       - On overflow the accumulator clamps to +max (2^(ACC_W-1)-1) or -min (-2^(ACC_W-1)),
//         according to the sign of the true result.
//       - Later beats keep adding to the clamped value with the same clamping rule.
//       - out_ovf is still set.
//     - Undefined: two's complement wrap-around; out_ovf flags only.
// STRUCTURE
//   - Shared package booth_pkg:
//     - Localparams PROD_W = 2*WIDTH and the default ACC_W.
//     - FSM state enum (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2).
//     - Function sext_prod() for the ACC_W sign extension.
//   - One sub-module, booth_acc_add: ACC_W add plus overflow detect and the optional
//     ACC_SATURATE_EN clamp (purely combinational).
//   - FSM, counter and output registers live in booth_prod_accum.
// TESTING
//   1. Frame of 3 beats {in_p=6, -2, 10}, last on beat 3, out_ready=1
//      -> out_valid one cycle later, out_acc=14, out_cnt=3, out_ovf=0.
//   2. Single beat in_p=64'h8000_0000_0000_0000 with in_last
//      -> out_acc = sign-extended -2^63, out_cnt=1.
//   3. ACC_W=64, two beats of 64'h7FFF_FFFF_FFFF_FFFF:
//      - Without ACC_SATURATE_EN: out_acc=64'hFFFF_FFFF_FFFF_FFFE, out_ovf=1.
//      - With ACC_SATURATE_EN: out_acc=64'h7FFF_FFFF_FFFF_FFFF, out_ovf=1.
//   4. out_ready held 0 for 5 cycles in HOLD with in_valid=1
//      -> in_ready=0, out_acc stable, no beat lost; after out_ready=1 the next frame starts
//         from its first beat.
//   5. acc_clr with in_valid=1 mid-frame (after 2 beats)
//      -> that beat not consumed; the next frame {3 last} gives out_acc=3, out_cnt=1.
//   6. rst_n pulsed low asynchronously (between clk edges) during ACCUM
//      -> all outputs 0 immediately, in_ready=1 after release, no out_valid.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, FSM state encoding and product sign extension
// for the Booth multiply-accumulate stage.
package booth_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int PROD_W    = 2 * DEF_WIDTH;
  localparam int DEF_ACC_W = 72;
  localparam int DEF_CNT_W = 16;
  localparam int SEXT_W    = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Replicates bit pw-1 of p into every higher bit; caller slices the width it needs.
  function automatic logic [SEXT_W-1:0] sext_prod(input logic [SEXT_W-1:0] p, input int pw);
    logic [SEXT_W-1:0] r;
    for (int i = 0; i < SEXT_W; i++) begin
      r[i] = (i < pw) ? p[i] : p[pw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_prod_accum_if.sv
// rtl/booth_prod_accum_if.sv - product input stream and frame result stream of the
// accumulate stage.
interface booth_prod_accum_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_p;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/booth_acc_add.sv
// rtl/booth_acc_add.sv - accumulator adder with signed overflow detect; ACC_SATURATE_EN
// selects clamping instead of wrap-around.
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  // On overflow the true result carries the common operand sign.
  assign sum = !ovf         ? raw :
               a[ACC_W-1]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                              {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_prod_accum.sv
// rtl/booth_prod_accum.sv - streaming accumulate stage behind the Booth multiplier; sums
// a frame of products and holds the total until taken. ACC_SATURATE_EN enables clamping.
module booth_prod_accum
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  booth_prod_accum_if.slave bus
);

  localparam int P_W = 2 * WIDTH;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              valid_q;
  logic [SEXT_W-1:0] p_wide;
  logic [ACC_W-1:0]  p_ext;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic              take;
  logic              unused_hi;

  assign p_wide    = sext_prod(SEXT_W'(bus.in_p), P_W);
  assign p_ext     = p_wide[ACC_W-1:0];
  assign unused_hi = ^p_wide[SEXT_W-1:ACC_W];

  // acc_clr wins over a same-cycle beat, so the beat must not look accepted.
  assign bus.in_ready = (state != HOLD) && !acc_clr;
  assign take         = bus.in_valid && bus.in_ready;

  assign bus.out_valid = valid_q;
  assign bus.out_acc   = acc;
  assign bus.out_cnt   = cnt;
  assign bus.out_ovf   = ovf;

  booth_acc_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (p_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else if (acc_clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            acc     <= p_ext;
            cnt     <= CNT_W'(1);
            ovf     <= 1'b0;
            state   <= bus.in_last ? HOLD : ACCUM;
            valid_q <= bus.in_last;
          end
        end
        ACCUM: begin
          if (take) begin
            acc <= sum;
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
            ovf <= ovf | sum_ovf;
            if (bus.in_last) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
// tb/tb_booth_prod_accum.sv - table, corner-case and randomized checks of booth_prod_accum
// against an arithmetic reference model.
module tb_booth_prod_accum;

  localparam int W  = 32;
  localparam int AW = 72;
  localparam int CW = 16;

  typedef struct {
    int          len;
    logic [63:0] p [4];
    logic [71:0] acc;
    int          cnt;
    bit          ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic acc_clr;
  logic clr64;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  booth_prod_accum_if #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) bus ();
  booth_prod_accum_if #(.WIDTH(W), .ACC_W(64), .CNT_W(CW)) bus64 ();

  booth_prod_accum #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .bus(bus)
  );

  booth_prod_accum #(.WIDTH(W), .ACC_W(64), .CNT_W(CW)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .acc_clr(clr64), .bus(bus64)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: exact integer sum, range-checked against an aw-bit signed accumulator.
  function automatic logic signed [127:0] mdl_step(input logic signed [127:0] acc,
                                                   input logic [63:0] p, input int aw,
                                                   output bit ov);
    logic signed [127:0] t, pe, mx, mn, m;
    pe = {{64{p[63]}}, p};
    t  = acc + pe;
    m  = 128'sd1 <<< aw;
    mx = (128'sd1 <<< (aw - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    ov = (t > mx) || (t < mn);
`ifdef ACC_SATURATE_EN
    if (t > mx) t = mx;
    else if (t < mn) t = mn;
`else
    if (t > mx) t = t - m;
    else if (t < mn) t = t + m;
`endif
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the beat transferred.
  task automatic send_beat(input logic [63:0] p, input logic last);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_timeout: in_ready stayed 0, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input logic [63:0] ps [8], input int n, input int gap_max,
                           input int stall, output logic [71:0] acc,
                           output logic [15:0] cnt, output logic ovf);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
      send_beat(ps[i], (i == n - 1));
    end
    @(negedge clk);
    check("latency_out_valid", 128'(bus.out_valid), 128'(1));
    repeat (stall) @(negedge clk);
    acc = bus.out_acc;
    cnt = bus.out_cnt;
    ovf = bus.out_ovf;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t                vt [6];
    logic [63:0]         ps [8];
    logic [71:0]         g_acc;
    logic [15:0]         g_cnt;
    logic                g_ovf;
    logic signed [127:0] m_acc;
    bit                  m_ovf, ov;
    int                  n;

    vt[0].len = 3; vt[0].p[0] = 64'd6; vt[0].p[1] = -64'sd2; vt[0].p[2] = 64'd10;
    vt[0].acc = 72'd14; vt[0].cnt = 3; vt[0].ovf = 1'b0;
    vt[1].len = 1; vt[1].p[0] = 64'h8000_0000_0000_0000;
    vt[1].acc = 72'hFF_8000_0000_0000_0000; vt[1].cnt = 1; vt[1].ovf = 1'b0;
    vt[2].len = 4;
    for (int i = 0; i < 4; i++) vt[2].p[i] = 64'h7FFF_FFFF_FFFF_FFFF;
    vt[2].acc = 72'h01_FFFF_FFFF_FFFF_FFFC; vt[2].cnt = 4; vt[2].ovf = 1'b0;
    vt[3].len = 2; vt[3].p[0] = -64'sd1; vt[3].p[1] = -64'sd1;
    vt[3].acc = 72'hFF_FFFF_FFFF_FFFF_FFFE; vt[3].cnt = 2; vt[3].ovf = 1'b0;
    vt[4].len = 3;
    for (int i = 0; i < 3; i++) vt[4].p[i] = 64'h8000_0000_0000_0000;
    vt[4].acc = 72'hFE_8000_0000_0000_0000; vt[4].cnt = 3; vt[4].ovf = 1'b0;
    vt[5].len = 2; vt[5].p[0] = 64'd100; vt[5].p[1] = -64'sd100;
    vt[5].acc = 72'd0; vt[5].cnt = 2; vt[5].ovf = 1'b0;

    rst_n = 1'b0; acc_clr = 1'b0; clr64 = 1'b0;
    bus.in_valid = 0; bus.in_p = '0; bus.in_last = 0; bus.out_ready = 0;
    bus64.in_valid = 0; bus64.in_p = '0; bus64.in_last = 0; bus64.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_acc", 128'(bus.out_acc), 128'(0));
    check("rst_out_cnt", 128'(bus.out_cnt), 128'(0));
    check("rst_out_ovf", 128'(bus.out_ovf), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) ps[i] = (i < 4) ? vt[v].p[i % 4] : 64'd0;
      run_frame(ps, vt[v].len, 0, v % 3, g_acc, g_cnt, g_ovf);
      check($sformatf("vec%0d_acc", v), 128'(g_acc), 128'(vt[v].acc));
      check($sformatf("vec%0d_cnt", v), 128'(g_cnt), 128'(vt[v].cnt));
      check($sformatf("vec%0d_ovf", v), 128'(g_ovf), 128'(vt[v].ovf));
    end

    // Two max-positive beats into a 64-bit accumulator must overflow.
    bus64.in_valid = 1'b1; bus64.in_p = 64'h7FFF_FFFF_FFFF_FFFF; bus64.in_last = 1'b0;
    @(negedge clk);
    check("acc64_ready0", 128'(bus64.in_ready), 128'(1));
    @(posedge clk);
    #1;
    bus64.in_last = 1'b1;
    @(negedge clk);
    check("acc64_ready1", 128'(bus64.in_ready), 128'(1));
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0; bus64.in_last = 1'b0;
    @(negedge clk);
    check("acc64_valid", 128'(bus64.out_valid), 128'(1));
`ifdef ACC_SATURATE_EN
    check("acc64_acc", 128'(bus64.out_acc), 128'(64'h7FFF_FFFF_FFFF_FFFF));
`else
    check("acc64_acc", 128'(bus64.out_acc), 128'(64'hFFFF_FFFF_FFFF_FFFE));
`endif
    check("acc64_ovf", 128'(bus64.out_ovf), 128'(1));
    check("acc64_cnt", 128'(bus64.out_cnt), 128'(2));
    bus64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus64.out_ready = 1'b0;

    // Back-pressure in HOLD: next frame's beat must wait, not be lost.
    send_beat(64'd1, 1'b0);
    send_beat(64'd2, 1'b1);
    bus.in_valid = 1'b1; bus.in_p = 64'd5; bus.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_in_ready", k), 128'(bus.in_ready), 128'(0));
      check($sformatf("hold%0d_acc", k), 128'(bus.out_acc), 128'(3));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("hold_release_ready", 128'(bus.in_ready), 128'(1));
    check("hold_release_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    check("hold_next_valid", 128'(bus.out_valid), 128'(1));
    check("hold_next_acc", 128'(bus.out_acc), 128'(5));
    check("hold_next_cnt", 128'(bus.out_cnt), 128'(1));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // acc_clr mid-frame drops the frame and the beat offered with it.
    send_beat(64'd7, 1'b0);
    send_beat(64'd8, 1'b0);
    bus.in_valid = 1'b1; bus.in_p = 64'd100; bus.in_last = 1'b1; acc_clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    acc_clr = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    check("clr_acc", 128'(bus.out_acc), 128'(0));
    check("clr_cnt", 128'(bus.out_cnt), 128'(0));
    check("clr_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    ps[0] = 64'd3;
    run_frame(ps, 1, 0, 0, g_acc, g_cnt, g_ovf);
    check("clr_next_acc", 128'(g_acc), 128'(3));
    check("clr_next_cnt", 128'(g_cnt), 128'(1));

    // Asynchronous reset between edges during ACCUM.
    send_beat(64'd7, 1'b0);
    send_beat(64'd8, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_acc", 128'(bus.out_acc), 128'(0));
    check("arst_cnt", 128'(bus.out_cnt), 128'(0));
    check("arst_ovf", 128'(bus.out_ovf), 128'(0));
    check("arst_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (3) @(negedge clk);
    check("arst_no_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(6, 1);
      m_acc = '0;
      m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(3, 0))
          0: ps[i] = 64'($signed($urandom_range(2000, 0)) - 1000);
          1: ps[i] = {$urandom, $urandom};
          2: ps[i] = 64'h7FFF_FFFF_FFFF_FFFF;
          default: ps[i] = 64'h8000_0000_0000_0000;
        endcase
        if (i < n) begin
          m_acc = mdl_step(m_acc, ps[i], AW, ov);
          m_ovf = m_ovf | ov;
        end
      end
      run_frame(ps, n, 2, $urandom_range(3, 0), g_acc, g_cnt, g_ovf);
      check($sformatf("rand%0d_acc", f), 128'(g_acc), 128'(m_acc[71:0]));
      check($sformatf("rand%0d_cnt", f), 128'(g_cnt), 128'(n));
      check($sformatf("rand%0d_ovf", f), 128'(g_ovf), 128'(m_ovf));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
